// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the fixed-point arithmetic blocks (fp_mul, fp_div).
//   - state_e : divider control states IDLE / CALC / DONE
//   - ITER    : iteration count for the default (Q=6, N=16) format, N-1+Q
//   - CNT_W   : counter width able to hold ITER
//   - sm_to_tc: sign-magnitude <-> two's-complement conversion. Negation is its
//               own inverse, so the same helper serves both directions.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_Q = 6;
    localparam int DEF_N = 16;
    localparam int ITER  = DEF_N - 1 + DEF_Q;
    localparam int CNT_W = $clog2(ITER + 1);

    // Callers zero-extend into 64 bits and truncate the result back to their width.
    function automatic logic [63:0] sm_to_tc(input logic neg, input logic [63:0] mag);
        return neg ? (~mag + 64'd1) : mag;
    endfunction

endpackage

// File: rtl/fp_div_step.sv
// fp_div_step: one restoring radix-2 division iteration (combinational).
// Ports:
//   rem_i  [N-1:0] partial remainder before this iteration
//   bit_i          next numerator bit, shifted into the remainder LSB
//   dmag_i [N-2:0] divisor magnitude
//   rem_o  [N-1:0] partial remainder after this iteration
//   qbit_o         quotient bit produced by this iteration
module fp_div_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-2:0] dmag_i,
    output logic [N-1:0] rem_o,
    output logic         qbit_o
);

    logic [N-1:0] shifted;
    logic [N:0]   trial;

    always_comb begin
        shifted = {rem_i[N-2:0], bit_i};
        trial   = {1'b0, shifted} - {2'b00, dmag_i};
        // A set remainder MSB means the true shifted value is at least 2^N and
        // therefore exceeds any divisor magnitude; the low N bits of the
        // difference are still the correct new remainder in that case.
        qbit_o  = rem_i[N-1] | ~trial[N];
        rem_o   = qbit_o ? trial[N-1:0] : shifted;
    end

endmodule

// File: rtl/fp_div.sv
// fp_div: sequential signed fixed-point divider, (Q,N) format |S|I..I|F..F|.
// One quotient bit per clock; start/done handshake.
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start          request, accepted when busy=0 (IDLE or DONE)
//   dividend_in    signed dividend, (Q,N)
//   divisor_in     signed divisor, (Q,N)
//   busy           high while an operation is in progress
//   done           one-cycle pulse; results valid from this cycle
//   quot_out       signed quotient, (Q,N), truncated toward zero
//   overflow       quotient magnitude does not fit in N-1 bits
//   div_by_zero    divisor magnitude was zero
// Build option: FP_DIV_SATURATE_EN clamps quot_out to the largest magnitude
// of the right sign on overflow; without it the low N-1 bits wrap.
module fp_div
    import fp_pkg::*;
#(
    parameter int Q = 6,
    parameter int N = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] dividend_in,
    input  logic signed [N-1:0] divisor_in,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] quot_out,
    output logic                overflow,
    output logic                div_by_zero
);

    localparam int NITER  = N - 1 + Q;
    localparam int NCNT_W = $clog2(NITER + 1);
    localparam logic [NCNT_W-1:0] CNT_LAST = NCNT_W'(NITER);
    // A zero divisor skips straight to the last iteration so it finishes in
    // two cycles while sharing the normal result path.
    localparam logic [NCNT_W-1:0] CNT_DBZ  = NCNT_W'(NITER - 1);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-2){1'b0}}, 1'b1};

    state_e              state_q;
    logic [NCNT_W-1:0]   cnt_q;
    logic [N-2:0]        dmag_q;
    logic [NITER-1:0]    num_q;
    logic [NITER-1:0]    quo_q;
    logic [N-1:0]        rem_q;
    logic                sign_q;
    logic                dbz_q;
    logic                busy_q;
    logic                done_q;
    logic [N-1:0]        quot_q;
    logic                ovf_q;
    logic                dbzo_q;

    logic [N-2:0]        dvd_mag_d;
    logic [N-2:0]        dvs_mag_d;
    logic [N-1:0]        rem_d;
    logic                qbit_d;
    logic [N-2:0]        res_mag_d;
    logic [N-2:0]        res_neg_d;
    logic                res_ovf_d;
    logic [N-1:0]        res_quot_d;

    // Operand magnitudes (most-negative input maps to magnitude 0)
    always_comb begin
        dvd_mag_d = (N-1)'(sm_to_tc(dividend_in[N-1], 64'(dividend_in[N-2:0])));
        dvs_mag_d = (N-1)'(sm_to_tc(divisor_in[N-1],  64'(divisor_in[N-2:0])));
    end

    fp_div_step #(.N(N)) u_step (
        .rem_i  (rem_q),
        .bit_i  (num_q[NITER-1]),
        .dmag_i (dmag_q),
        .rem_o  (rem_d),
        .qbit_o (qbit_d)
    );

    // Result formatting from the finished quotient register
    always_comb begin
        res_mag_d  = quo_q[N-2:0];
        res_ovf_d  = |quo_q[NITER-1:N-1];
        res_neg_d  = (N-1)'(sm_to_tc(1'b1, 64'(res_mag_d)));
        res_quot_d = {1'b0, res_mag_d};
        if (sign_q && (res_mag_d != '0)) begin
            res_quot_d = {1'b1, res_neg_d};
        end
`ifdef FP_DIV_SATURATE_EN
        if (res_ovf_d) begin
            res_quot_d = sign_q ? MAX_NEG : MAX_POS;
        end
`endif
        if (dbz_q) begin
            res_ovf_d  = 1'b0;
            res_quot_d = sign_q ? MAX_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dmag_q  <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            sign_q  <= 1'b0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
            dbzo_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        dmag_q  <= dvs_mag_d;
                        num_q   <= {dvd_mag_d, {Q{1'b0}}};
                        quo_q   <= '0;
                        rem_q   <= '0;
                        sign_q  <= dividend_in[N-1] ^ divisor_in[N-1];
                        dbz_q   <= (dvs_mag_d == '0);
                        cnt_q   <= (dvs_mag_d == '0) ? CNT_DBZ : '0;
                        ovf_q   <= 1'b0;
                        dbzo_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt_q == CNT_LAST) begin
                        quot_q  <= res_quot_d;
                        ovf_q   <= res_ovf_d;
                        dbzo_q  <= dbz_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        num_q <= num_q << 1;
                        quo_q <= {quo_q[NITER-2:0], qbit_d};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot_out    = quot_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbzo_q;

endmodule
